// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//   Initiator for the team's combinational ALU. A command (op, x, y, use_acc)
//   is accepted over a valid/ready handshake and registered onto the ALU
//   inputs. After SETTLE cycles the ALU result and flags are captured and
//   returned over a second valid/ready handshake. The captured result is also
//   kept in an accumulator so a following command can take x from it.
//   At most one operation is outstanding at any time.
//
// Parameters
//   WIDTH   operand/result width, must match the attached ALU
//   SETTLE  cycles from command accept to result capture (1..15)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op, cmd_x, cmd_y        ALU sel code and operands
//   cmd_use_acc                 take x from the accumulator instead of cmd_x
//   alu_x, alu_y, alu_sel       registered drive to the ALU
//   alu_res, alu_of/cf/zf       ALU result and flags
//   rsp_valid/rsp_ready         response handshake
//   rsp_res, rsp_flags          captured result and {OF,CF,ZF}
//   busy                        high whenever an operation is in progress
//
// Optional feature (macro ALU_STICKY_FLAGS_EN)
//   sticky_clr in, sticky_of/sticky_cf out: accumulated overflow/carry flags
//   over all captures since the last clear.
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_of,
    input  logic             alu_cf,
    input  logic             alu_zf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_res,
    output logic [2:0]       rsp_flags,
    output logic             busy
`ifdef ALU_STICKY_FLAGS_EN
    ,
    input  logic             sticky_clr,
    output logic             sticky_of,
    output logic             sticky_cf
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Counter reload: capture happens when the count reaches zero, so a
    // reload of SETTLE-1 places the capture edge SETTLE edges after accept.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    logic [1:0]       state_q,     state_d;
    logic [3:0]       cnt_q,       cnt_d;
    logic [WIDTH-1:0] alu_x_q,     alu_x_d;
    logic [WIDTH-1:0] alu_y_q,     alu_y_d;
    logic [2:0]       alu_sel_q,   alu_sel_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [WIDTH-1:0] rsp_res_q,   rsp_res_d;
    logic [2:0]       rsp_flags_q, rsp_flags_d;
    logic             capture;

    assign capture = (state_q == WAIT) && (cnt_q == 4'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_x_d     = alu_x_q;
        alu_y_d     = alu_y_q;
        alu_sel_d   = alu_sel_q;
        acc_d       = acc_q;
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_x_d   = cmd_use_acc ? acc_q : cmd_x;
                    alu_y_d   = cmd_y;
                    alu_sel_d = cmd_op;
                    cnt_d     = CNT_INIT;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_res_d   = alu_res;
                    rsp_flags_d = {alu_of, alu_cf, alu_zf};
                    acc_d       = alu_res;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_sel_q   <= '0;
            acc_q       <= '0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_x_q     <= alu_x_d;
            alu_y_q     <= alu_y_d;
            alu_sel_q   <= alu_sel_d;
            acc_q       <= acc_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_flags = rsp_flags_q;

`ifdef ALU_STICKY_FLAGS_EN
    // Bit 1 = overflow, bit 0 = carry. A clear coinciding with a capture
    // still lets the new capture's flags through.
    logic [1:0] sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_clr ? 2'b00 : sticky_q;
        if (capture) begin
            sticky_d = sticky_d | {alu_of, alu_cf};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 2'b00;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_of = sticky_q[1];
    assign sticky_cf = sticky_q[0];
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//   Two sequencers (SETTLE=1 and SETTLE=3) share the command/response inputs,
//   each paired with its own behavioural 4-bit ALU. A transaction-level model
//   predicts every output of both instances each cycle; directed scenarios
//   pin the model with hand-computed values, then random traffic runs.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_x = 4'd0;
    logic [3:0] cmd_y = 4'd0;
    logic       cmd_use_acc = 1'b0;
    logic       rsp_ready = 1'b0;

    logic [1:0]      cmd_ready, rsp_valid, busy;
    logic [1:0][3:0] alu_x, alu_y, alu_res, rsp_res;
    logic [1:0][2:0] alu_sel, rsp_flags;
    logic [1:0]      alu_of, alu_cf, alu_zf;
`ifdef ALU_STICKY_FLAGS_EN
    logic       sticky_clr = 1'b0;
    logic [1:0] sticky_of, sticky_cf;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Team ALU behaviour: returns {res, OF, CF, ZF}.
    function automatic logic [6:0] alu_f(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
        logic [4:0] s;
        logic [3:0] r;
        logic       o, c;
        o = 1'b0; c = 1'b0; s = 5'd0;
        case (op)
            3'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[3:0]; c = s[4]; o = (x[3] == y[3]) && (r[3] != x[3]); end
            3'd1: begin s = {1'b0, x} + {1'b0, ~y} + 5'd1; r = s[3:0]; c = s[4]; o = (x[3] != y[3]) && (r[3] != x[3]); end
            3'd2: r = ~x;
            3'd3: r = x & y;
            3'd4: r = x | y;
            3'd5: r = x ^ y;
            3'd6: r = {3'b000, x > y};
            default: r = {3'b000, x == y};
        endcase
        return {r, o, c, r == 4'd0};
    endfunction

    assign {alu_res[0], alu_of[0], alu_cf[0], alu_zf[0]} = alu_f(alu_sel[0], alu_x[0], alu_y[0]);
    assign {alu_res[1], alu_of[1], alu_cf[1], alu_zf[1]} = alu_f(alu_sel[1], alu_x[1], alu_y[1]);

    alu_cmd_sequencer #(.WIDTH(4), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_use_acc(cmd_use_acc),
        .alu_x(alu_x[0]), .alu_y(alu_y[0]), .alu_sel(alu_sel[0]), .alu_res(alu_res[0]),
        .alu_of(alu_of[0]), .alu_cf(alu_cf[0]), .alu_zf(alu_zf[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_res(rsp_res[0]),
        .rsp_flags(rsp_flags[0]), .busy(busy[0])
`ifdef ALU_STICKY_FLAGS_EN
        , .sticky_clr(sticky_clr), .sticky_of(sticky_of[0]), .sticky_cf(sticky_cf[0])
`endif
    );

    alu_cmd_sequencer #(.WIDTH(4), .SETTLE(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_use_acc(cmd_use_acc),
        .alu_x(alu_x[1]), .alu_y(alu_y[1]), .alu_sel(alu_sel[1]), .alu_res(alu_res[1]),
        .alu_of(alu_of[1]), .alu_cf(alu_cf[1]), .alu_zf(alu_zf[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_res(rsp_res[1]),
        .rsp_flags(rsp_flags[1]), .busy(busy[1])
`ifdef ALU_STICKY_FLAGS_EN
        , .sticky_clr(sticky_clr), .sticky_of(sticky_of[1]), .sticky_cf(sticky_cf[1])
`endif
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Transaction model: an outstanding op is "aged" in edges since accept;
    // its response is visible once the age reaches SETTLE.
    logic       m_out[2];
    int         m_age[2];
    logic [3:0] m_acc[2], m_x[2], m_y[2], m_res[2], m_pres[2];
    logic [2:0] m_sel[2], m_flags[2], m_pflags[2];

    always @(posedge clk or negedge rst_n) begin : model
        logic [3:0] xe;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_out[d] = 1'b0; m_age[d] = 0; m_acc[d] = 4'd0; m_x[d] = 4'd0; m_y[d] = 4'd0;
                m_sel[d] = 3'd0; m_res[d] = 4'd0; m_flags[d] = 3'd0; m_pres[d] = 4'd0; m_pflags[d] = 3'd0;
            end else if (!m_out[d]) begin
                if (cmd_valid) begin
                    xe = cmd_use_acc ? m_acc[d] : cmd_x;
                    m_x[d] = xe; m_y[d] = cmd_y; m_sel[d] = cmd_op;
                    {m_pres[d], m_pflags[d]} = alu_f(cmd_op, xe, cmd_y);
                    m_acc[d] = m_pres[d];
                    m_out[d] = 1'b1; m_age[d] = 0;
                end
            end else if (m_age[d] >= settle_of(d)) begin
                if (rsp_ready) m_out[d] = 1'b0;
            end else begin
                m_age[d]++;
                if (m_age[d] == settle_of(d)) begin
                    m_res[d] = m_pres[d]; m_flags[d] = m_pflags[d];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("m%0d.cmd_ready", d), 8'(cmd_ready[d]), 8'(!m_out[d]));
                check($sformatf("m%0d.rsp_valid", d), 8'(rsp_valid[d]), 8'(m_out[d] && (m_age[d] >= settle_of(d))));
                check($sformatf("m%0d.busy", d), 8'(busy[d]), 8'(m_out[d]));
                check($sformatf("m%0d.alu_x", d), 8'(alu_x[d]), 8'(m_x[d]));
                check($sformatf("m%0d.alu_y", d), 8'(alu_y[d]), 8'(m_y[d]));
                check($sformatf("m%0d.alu_sel", d), 8'(alu_sel[d]), 8'(m_sel[d]));
                check($sformatf("m%0d.rsp_res", d), 8'(rsp_res[d]), 8'(m_res[d]));
                check($sformatf("m%0d.rsp_flags", d), 8'(rsp_flags[d]), 8'(m_flags[d]));
            end
        end
    end

    // Drivers: all are entered and left just after a falling edge.
    task automatic do_cmd(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y, input logic ua);
        int n;
        cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_use_acc = ua;
        n = 0;
        while (!cmd_ready[0] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("accept_timeout", 8'd0, 8'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [3:0] r, output logic [2:0] f);
        int n;
        n = 0;
        while (!rsp_valid[0] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("rsp_timeout", 8'd0, 8'd1);
        r = rsp_res[0]; f = rsp_flags[0];
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic drain();
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        repeat (8) @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] r;
        logic [2:0] f;
        int n;
        repeat (2) @(negedge clk);
        check("reset.cmd_ready", 8'(cmd_ready), 8'b11);
        check("reset.rsp_valid", 8'(rsp_valid), 8'b00);
        check("reset.busy", 8'(busy), 8'b00);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: 7+1 overflows, response one cycle after accept
        do_cmd(3'd0, 4'd7, 4'd1, 1'b0);
        check("t1.rsp_valid_accept_cycle", 8'(rsp_valid[0]), 8'd0);
        @(negedge clk);
        check("t1.rsp_valid_next_cycle", 8'(rsp_valid[0]), 8'd1);
        get_rsp(r, f);
        check("t1.res", 8'(r), 8'd8);
        check("t1.flags", 8'(f), 8'b100);
        check("t1.cmd_ready_after_hs", 8'(cmd_ready[0]), 8'd1);

        // T2: 3-3 and 5==5
        do_cmd(3'd1, 4'd3, 4'd3, 1'b0);
        get_rsp(r, f);
        check("t2.sub_res", 8'(r), 8'd0);
        check("t2.sub_flags", 8'(f), 8'b011);
        do_cmd(3'd7, 4'd5, 4'd5, 1'b0);
        get_rsp(r, f);
        check("t2.eq_res", 8'(r), 8'd1);

        // T3: accumulator chain; cmd_x is junk when use_acc is set
        do_cmd(3'd0, 4'd2, 4'd3, 1'b0);
        get_rsp(r, f);
        check("t3.res1", 8'(r), 8'd5);
        do_cmd(3'd0, 4'd15, 4'd4, 1'b1);
        get_rsp(r, f);
        check("t3.res2", 8'(r), 8'd9);
        do_cmd(3'd3, 4'd0, 4'd12, 1'b1);
        check("t3.alu_x", 8'(alu_x[0]), 8'd9);
        get_rsp(r, f);
        check("t3.res3", 8'(r), 8'd8);

        // T4: backpressure on the SETTLE=3 instance
        drain();
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_x = 4'd6; cmd_y = 4'd5; cmd_use_acc = 1'b0;
        @(negedge clk);
        cmd_op = 3'd4; cmd_x = 4'd1; cmd_y = 4'd2;
        n = 0;
        while (!rsp_valid[1] && n < 20) begin @(negedge clk); n++; end
        check("t4.rsp_arrives", 8'(n < 20), 8'd1);
        repeat (5) begin
            check("t4.rsp_valid_held", 8'(rsp_valid[1]), 8'd1);
            check("t4.rsp_res_held", 8'(rsp_res[1]), 8'd11);
            check("t4.rsp_flags_held", 8'(rsp_flags[1]), 8'b100);
            check("t4.cmd_ready_low", 8'(cmd_ready[1]), 8'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t4.cmd_ready_after_hs", 8'(cmd_ready[1]), 8'd1);
        check("t4.rsp_valid_after_hs", 8'(rsp_valid[1]), 8'd0);
        @(negedge clk);
        check("t4.pending_accepted", 8'(cmd_ready[1]), 8'd0);
        check("t4.new_sel", 8'(alu_sel[1]), 8'd4);
        check("t4.new_y", 8'(alu_y[1]), 8'd2);
        cmd_valid = 1'b0;

        // T5: asynchronous reset during WAIT
        drain();
        do_cmd(3'd0, 4'd1, 4'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t5.cmd_ready", 8'(cmd_ready), 8'b11);
        check("t5.rsp_valid", 8'(rsp_valid), 8'b00);
        check("t5.busy", 8'(busy), 8'b00);
        check("t5.alu_x", 8'(alu_x), 8'd0);
        check("t5.alu_y", 8'(alu_y), 8'd0);
        check("t5.alu_sel", 8'(alu_sel), 8'd0);
        check("t5.rsp_res", 8'(rsp_res), 8'd0);
        check("t5.rsp_flags", 8'(rsp_flags), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t5.no_response", 8'(rsp_valid), 8'b00);
        end
        do_cmd(3'd0, 4'd9, 4'd3, 1'b1);
        get_rsp(r, f);
        check("t5.acc_cleared", 8'(r), 8'd3);

`ifdef ALU_STICKY_FLAGS_EN
        // T6: sticky overflow survives a clean add, clear with a carry add
        drain();
        do_cmd(3'd0, 4'd7, 4'd1, 1'b0);
        get_rsp(r, f);
        do_cmd(3'd0, 4'd1, 4'd1, 1'b0);
        get_rsp(r, f);
        check("t6.sticky_of_held", 8'(sticky_of[0]), 8'd1);
        sticky_clr = 1'b1;
        do_cmd(3'd0, 4'd15, 4'd1, 1'b0);
        @(negedge clk);
        sticky_clr = 1'b0;
        get_rsp(r, f);
        check("t6.sticky_of_cleared", 8'(sticky_of[0]), 8'd0);
        check("t6.sticky_cf_set", 8'(sticky_cf[0]), 8'd1);
`endif

        // Random traffic, checked every cycle by the model compare
        drain();
        repeat (2000) begin
            cmd_valid   = 1'($urandom_range(0, 1));
            cmd_op      = 3'($urandom_range(0, 7));
            cmd_x       = 4'($urandom_range(0, 15));
            cmd_y       = 4'($urandom_range(0, 15));
            cmd_use_acc = 1'($urandom_range(0, 1));
            rsp_ready   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
